// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Purpose  : Shared types and defaults for the MIPS32 instruction-fetch stage.
//  Revision : 1.0  initial release
// ============================================================================
package fetch_pkg;

    localparam int unsigned INSTR_W      = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int unsigned PC_INC_DEF   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FLUSH = 2'd3
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_adder.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage_adder
//  Purpose  : Parameterised unsigned adder, result modulo 2^SIZE.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_stage_adder #(
    parameter int unsigned SIZE = 32
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic [SIZE-1:0] sum
);

    assign sum = a + b;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : PC owner and instruction-memory requester with a single-entry
//             IF/ID output register; one outstanding request at most.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_stage import fetch_pkg::*; #(
    parameter int unsigned      WIDTH    = INSTR_W,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF),
    parameter int unsigned      PC_INC   = PC_INC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_pc_plus4
);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] req_pc_q, req_pc_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_instr_q, out_instr_d;
    logic [WIDTH-1:0] out_pc_q, out_pc_d;
    logic [WIDTH-1:0] out_pc_plus4_q, out_pc_plus4_d;
    logic             stale_q, stale_d;
    logic [WIDTH-1:0] pc_next_seq;
    logic [WIDTH-1:0] redirect_aligned;

    fetch_stage_adder #(
        .SIZE (WIDTH)
    ) u_pc_adder (
        .a   (pc_q),
        .b   (WIDTH'(PC_INC)),
        .sum (pc_next_seq)
    );

    assign redirect_aligned = redirect_pc & ~WIDTH'(3);

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        req_pc_d       = req_pc_q;
        out_valid_d    = out_valid_q;
        out_instr_d    = out_instr_q;
        out_pc_d       = out_pc_q;
        out_pc_plus4_d = out_pc_plus4_q;
        imem_req       = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                imem_req = (!out_valid_q || out_ready) && !redirect_valid;
                if (imem_req && imem_gnt) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_next_seq;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    state_d = ST_ISSUE;
                    if (!redirect_valid) begin
                        out_instr_d    = imem_rdata;
                        out_pc_d       = req_pc_q;
                        out_pc_plus4_d = pc_q;
                        out_valid_d    = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (imem_rvalid) begin
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A redirect wins over any capture or consume this cycle; a request
        // still in flight must be drained through FLUSH before reissuing.
        if (redirect_valid) begin
            pc_d        = redirect_aligned;
            out_valid_d = 1'b0;
            if (state_q == ST_WAIT || state_q == ST_FLUSH) begin
                state_d = imem_rvalid ? ST_ISSUE : ST_FLUSH;
            end
        end
    end

    // Remembers a request abandoned by reset so its late response is tolerated.
    always_comb begin
        if (rst) begin
            stale_d = stale_q || (state_q == ST_WAIT) || (state_q == ST_FLUSH);
        end else begin
            stale_d = stale_q && !imem_rvalid;
        end
    end

    always_ff @(posedge clk) begin
        stale_q <= stale_d;
        if (rst) begin
            state_q        <= ST_IDLE;
            pc_q           <= RESET_PC;
            req_pc_q       <= '0;
            out_valid_q    <= 1'b0;
            out_instr_q    <= '0;
            out_pc_q       <= '0;
            out_pc_plus4_q <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            req_pc_q       <= req_pc_d;
            out_valid_q    <= out_valid_d;
            out_instr_q    <= out_instr_d;
            out_pc_q       <= out_pc_d;
            out_pc_plus4_q <= out_pc_plus4_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && imem_rvalid && !stale_q) begin
            assert (state_q == ST_WAIT || state_q == ST_FLUSH)
            else $error("fetch_stage: imem_rvalid with no outstanding request");
        end
    end

    assign imem_addr    = pc_q;
    assign out_valid    = out_valid_q;
    assign out_instr    = out_instr_q;
    assign out_pc       = out_pc_q;
    assign out_pc_plus4 = out_pc_plus4_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Directed self-checking bench for fetch_stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;

    int n_cmp = 0;
    int n_err = 0;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] instr,
                             input logic [31:0] pc, input logic [31:0] pc4);
        check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        check({tag, ".instr"}, out_instr, instr);
        check({tag, ".pc"}, out_pc, pc);
        check({tag, ".pc4"}, out_pc_plus4, pc4);
    endtask

    task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
        check({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
        check({tag, ".addr"}, imem_addr, addr);
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; out_ready = 1'b1;

        // Reset state
        tick(); tick();
        #1;
        check_out("reset", 1'b0, 32'h0, 32'h0, 32'h0);
        check_req("reset", 1'b0, 32'h0);
        rst = 1'b0; imem_gnt = 1'b1;
        #1;
        check_req("idle", 1'b0, 32'h0);

        // Sequential flow: grant, rvalid next cycle, one instruction per 2 cycles
        tick(); #1;
        check_req("seq0_issue", 1'b1, 32'h0);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0001; #1;
        check_req("seq0_wait", 1'b0, 32'h4);
        tick();
        imem_rvalid = 1'b0; #1;
        check_out("seq0_out", 1'b1, 32'hAAAA_0001, 32'h0, 32'h4);
        check_req("seq1_issue", 1'b1, 32'h4);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hBBBB_0002; #1;
        check("seq1_consumed", {31'd0, out_valid}, 32'd0);
        tick();
        imem_rvalid = 1'b0; #1;
        check_out("seq1_out", 1'b1, 32'hBBBB_0002, 32'h4, 32'h8);
        check_req("seq2_issue", 1'b1, 32'h8);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hCCCC_0003; #1;
        tick();
        imem_rvalid = 1'b0; out_ready = 1'b0; #1;
        check_out("seq2_out", 1'b1, 32'hCCCC_0003, 32'h8, 32'hC);

        // Backpressure: no request while the output register is full and stalled
        check_req("bp0", 1'b0, 32'hC);
        tick(); #1;
        check_req("bp1", 1'b0, 32'hC);
        tick(); #1;
        check_out("bp_hold", 1'b1, 32'hCCCC_0003, 32'h8, 32'hC);
        out_ready = 1'b1; #1;
        check_req("bp_release", 1'b1, 32'hC);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hDDDD_0004; #1;
        check("bp_consumed", {31'd0, out_valid}, 32'd0);
        check_req("bp_wait", 1'b0, 32'h10);
        tick();
        imem_rvalid = 1'b0; imem_gnt = 1'b0; #1;
        check_out("bp_out", 1'b1, 32'hDDDD_0004, 32'hC, 32'h10);

        // Grant stall: request held stable at the same address
        check_req("stall0", 1'b1, 32'h10);
        tick(); #1;
        check_req("stall1", 1'b1, 32'h10);
        tick(); #1;
        check_req("stall2", 1'b1, 32'h10);
        imem_gnt = 1'b1;
        tick(); #1;
        check_req("stall_granted", 1'b0, 32'h14);
        imem_rvalid = 1'b1; imem_rdata = 32'hEEEE_0005;
        tick();
        imem_rvalid = 1'b0; #1;
        check_out("stall_out", 1'b1, 32'hEEEE_0005, 32'h10, 32'h14);

        // Redirect during WAIT without rvalid -> FLUSH, late word discarded
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100; #1;
        check_req("rdw_wait", 1'b0, 32'h18);
        tick();
        redirect_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0; #1;
        check_req("rdw_flush", 1'b0, 32'h100);
        check("rdw_flush_valid", {31'd0, out_valid}, 32'd0);
        tick();
        imem_rvalid = 1'b0; #1;
        check_out("rdw_dropped", 1'b0, 32'hEEEE_0005, 32'h10, 32'h14);
        check_req("rdw_reissue", 1'b1, 32'h100);

        // Redirect coincident with rvalid -> data dropped, straight to ISSUE
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD1_BAD1; #1;
        tick();
        redirect_valid = 1'b0; imem_rvalid = 1'b0; #1;
        check("rdc_valid", {31'd0, out_valid}, 32'd0);
        check("rdc_instr", out_instr, 32'hEEEE_0005);
        check_req("rdc_reissue", 1'b1, 32'h200);

        // Wrap-around: low bits of the target are forced to zero
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE; #1;
        check_req("wrap_redirect", 1'b0, 32'h200);
        tick();
        redirect_valid = 1'b0; #1;
        check_req("wrap_issue", 1'b1, 32'hFFFF_FFFC);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678; #1;
        check_req("wrap_wait", 1'b0, 32'h0);
        tick();
        imem_rvalid = 1'b0; #1;
        check_out("wrap_out", 1'b1, 32'h1234_5678, 32'hFFFF_FFFC, 32'h0);
        check_req("wrap_next", 1'b1, 32'h0);

        // Reset while waiting on 0x20
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0020;
        tick();
        redirect_valid = 1'b0; #1;
        check_req("rstw_issue", 1'b1, 32'h20);
        tick();
        rst = 1'b1; #1;
        check_req("rstw_wait", 1'b0, 32'h24);
        tick();
        rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
        check_out("rstw_reset", 1'b0, 32'h0, 32'h0, 32'h0);
        check_req("rstw_idle", 1'b0, 32'h0);
        tick();
        imem_rvalid = 1'b0; #1;
        check_out("rstw_late", 1'b0, 32'h0, 32'h0, 32'h0);
        check_req("rstw_first", 1'b1, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
